// File: rtl/uart_frame_decoder.sv
// UART command-frame decoder: parses SYNC/CMD/ADDR/DATA/CHK frames into single
// memory requests and returns an ACK, NAK or read-data byte to the transmitter.
module uart_frame_decoder #(
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int unsigned TIMEOUT   = 65535,
    parameter logic [7:0]  ACK_BYTE  = 8'h06,
    parameter logic [7:0]  NAK_BYTE  = 8'h15
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       req_valid,
    input  logic       req_ready,
    output logic       req_we,
    output logic [7:0] req_addr,
    output logic [7:0] req_wdata,
    input  logic       rd_valid,
    input  logic [7:0] rd_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    output logic [7:0] err_cnt,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        GET_CMD,
        GET_ADDR,
        GET_DATA,
        GET_CHK,
        ISSUE,
        WAIT_RD,
        REPLY
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [7:0]  chk_q, chk_d;
    logic        chk_pend_q, chk_pend_d;
    logic [31:0] gap_q, gap_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic        req_valid_q, req_valid_d;
    logic        req_we_q, req_we_d;
    logic [7:0]  req_addr_q, req_addr_d;
    logic [7:0]  req_wdata_q, req_wdata_d;
    logic        tx_valid_q, tx_valid_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        busy_q, busy_d;

    logic        in_frame;
    logic        timeout;
    logic        err_evt;
    logic [31:0] gap_inc;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            chk_q       <= '0;
            chk_pend_q  <= 1'b0;
            gap_q       <= '0;
            err_cnt_q   <= '0;
            req_valid_q <= 1'b0;
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            chk_q       <= chk_d;
            chk_pend_q  <= chk_pend_d;
            gap_q       <= gap_d;
            err_cnt_q   <= err_cnt_d;
            req_valid_q <= req_valid_d;
            req_we_q    <= req_we_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        chk_d       = chk_q;
        chk_pend_d  = 1'b0;
        req_we_d    = req_we_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        tx_data_d   = tx_data_q;
        err_evt     = 1'b0;

        // The cycle after the CHK byte is the check step; the gap counter is idle there.
        in_frame = (state_q inside {GET_CMD, GET_ADDR, GET_DATA, GET_CHK}) && !chk_pend_q;
        gap_inc  = gap_q + 32'd1;
        timeout  = in_frame && (gap_inc == TIMEOUT);
        gap_d    = in_frame ? gap_inc : '0;

        case (state_q)
            IDLE: begin
                if (rx_valid && rx_data == SYNC_BYTE) begin
                    state_d = GET_CMD;
                end
            end
            GET_CMD: begin
                if (timeout) begin
                    state_d = IDLE;
                    err_evt = 1'b1;
                end else if (rx_valid) begin
                    cmd_d   = rx_data;
                    gap_d   = '0;
                    state_d = GET_ADDR;
                end
            end
            GET_ADDR: begin
                if (timeout) begin
                    state_d = IDLE;
                    err_evt = 1'b1;
                end else if (rx_valid) begin
                    req_addr_d = rx_data;
                    gap_d      = '0;
                    state_d    = GET_DATA;
                end
            end
            GET_DATA: begin
                if (timeout) begin
                    state_d = IDLE;
                    err_evt = 1'b1;
                end else if (rx_valid) begin
                    req_wdata_d = rx_data;
                    gap_d       = '0;
                    state_d     = GET_CHK;
                end
            end
            GET_CHK: begin
                if (chk_pend_q) begin
                    if (((cmd_q ^ req_addr_q ^ req_wdata_q) == chk_q) && (cmd_q[7:1] == 7'd0)) begin
                        req_we_d = cmd_q[0];
                        state_d  = ISSUE;
                    end else begin
                        tx_data_d = NAK_BYTE;
                        err_evt   = 1'b1;
                        state_d   = REPLY;
                    end
                end else if (timeout) begin
                    state_d = IDLE;
                    err_evt = 1'b1;
                end else if (rx_valid) begin
                    chk_d      = rx_data;
                    chk_pend_d = 1'b1;
                    gap_d      = '0;
                end
            end
            ISSUE: begin
                err_evt = rx_valid;
                if (req_ready) begin
                    if (req_we_q) begin
                        tx_data_d = ACK_BYTE;
                        state_d   = REPLY;
                    end else begin
                        state_d = WAIT_RD;
                    end
                end
            end
            WAIT_RD: begin
                err_evt = rx_valid;
                if (rd_valid) begin
                    tx_data_d = rd_data;
                    state_d   = REPLY;
                end
            end
            REPLY: begin
                err_evt = rx_valid;
                if (tx_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        err_cnt_d = (err_evt && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    always_comb begin
        req_valid_d = (state_d == ISSUE);
        tx_valid_d  = (state_d == REPLY);
        busy_d      = (state_d != IDLE);

        req_valid = req_valid_q;
        req_we    = req_we_q;
        req_addr  = req_addr_q;
        req_wdata = req_wdata_q;
        tx_valid  = tx_valid_q;
        tx_data   = tx_data_q;
        err_cnt   = err_cnt_q;
        busy      = busy_q;
    end

endmodule
